// File: rtl/sampler_pkg.sv
// Shared types and helpers for the weighted sampler.
// Holds the FSM state encoding, the sum width and the index-width function.
package sampler_pkg;

   localparam int SUM_W = 12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      SCAN    = 2'd2
   } state_e;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sampler_weight_table.sv
// Per-state weight registers with an incrementally maintained total.
// SAMPLER_UNIFORM_INIT_EN: reset every weight to 1 instead of 0.
module sampler_weight_table
   import sampler_pkg::*;
#(
   parameter int  NUM_STATES = 4,
   parameter int  WEIGHT_W   = 8,
   localparam int IDX_W      = idx_w(NUM_STATES)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                wr_en_i,
   input  logic [IDX_W-1:0]                    wr_addr_i,
   input  logic [WEIGHT_W-1:0]                 wr_data_i,
   output logic [NUM_STATES-1:0][WEIGHT_W-1:0] w_o,
   output logic [SUM_W-1:0]                    sum_o
);

   logic [NUM_STATES-1:0][WEIGHT_W-1:0] w_q, w_d;
   logic [SUM_W-1:0]                    sum_q, sum_d;
   logic                                addr_ok;

   assign addr_ok = (wr_addr_i <= IDX_W'(NUM_STATES - 1));

   // Swap the old weight out of the total and the new one in.
   always_comb begin
      w_d   = w_q;
      sum_d = sum_q;
      if (wr_en_i && addr_ok) begin
         w_d[wr_addr_i] = wr_data_i;
         sum_d = sum_q - SUM_W'(w_q[wr_addr_i]) + SUM_W'(wr_data_i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
`ifdef SAMPLER_UNIFORM_INIT_EN
         w_q   <= {NUM_STATES{WEIGHT_W'(1)}};
         sum_q <= SUM_W'(NUM_STATES);
`else
         w_q   <= '0;
         sum_q <= '0;
`endif
      end else begin
         w_q   <= w_d;
         sum_q <= sum_d;
      end
   end

   assign w_o   = w_q;
   assign sum_o = sum_q;

endmodule

// File: rtl/weighted_sampler.sv
// Weighted random state selector: cumulative-weight scan against a latched r.
// SAMPLER_UNIFORM_INIT_EN: weights reset to 1 (sum = NUM_STATES).
module weighted_sampler
   import sampler_pkg::*;
#(
   parameter int  NUM_STATES = 4,
   parameter int  WEIGHT_W   = 8,
   localparam int IDX_W      = idx_w(NUM_STATES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                w_wr_en,
   input  logic [IDX_W-1:0]    w_wr_addr,
   input  logic [WEIGHT_W-1:0] w_wr_data,
   input  logic                start,
   input  logic [SUM_W-1:0]    rand_in,
   output logic [SUM_W-1:0]    sum,
   output logic                busy,
   output logic                sel_valid,
   output logic [IDX_W-1:0]    sel_idx,
   output logic                err
);

   if (NUM_STATES < 2 || NUM_STATES > 16) begin : g_bad_states
      $error("weighted_sampler: NUM_STATES must be 2..16");
   end

   if (NUM_STATES * ((1 << WEIGHT_W) - 1) > 4095) begin : g_bad_width
      $error("weighted_sampler: total weight can exceed 12 bits");
   end

   state_e state_q, state_d;

   logic [SUM_W-1:0] r_q, r_d;
   logic [SUM_W-1:0] cum_q, cum_d;
   logic [SUM_W-1:0] cum_nxt;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
   logic             sel_valid_q, sel_valid_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] last_nz;
   logic             wr_ok;

   logic [NUM_STATES-1:0][WEIGHT_W-1:0] w;

   assign wr_ok = w_wr_en && (state_q == IDLE);

   sampler_weight_table #(
      .NUM_STATES(NUM_STATES),
      .WEIGHT_W  (WEIGHT_W)
   ) u_table (
      .clk_i    (clk),
      .rst_i    (reset),
      .wr_en_i  (wr_ok),
      .wr_addr_i(w_wr_addr),
      .wr_data_i(w_wr_data),
      .w_o      (w),
      .sum_o    (sum)
   );

   // Fallback target when r == sum: the highest index that can be drawn.
   always_comb begin
      last_nz = '0;
      for (int i = 0; i < NUM_STATES; i++) begin
         if (w[i] != '0) begin
            last_nz = IDX_W'(i);
         end
      end
   end

   assign cum_nxt = cum_q + SUM_W'(w[idx_q]);

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      cum_d       = cum_q;
      idx_d       = idx_q;
      sel_idx_d   = sel_idx_q;
      sel_valid_d = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            r_d   = rand_in;
            cum_d = '0;
            idx_d = '0;
            if (sum != '0) begin
               state_d = SCAN;
            end else begin
               state_d     = IDLE;
               err_d       = 1'b1;
               sel_valid_d = 1'b1;
               sel_idx_d   = '0;
            end
         end
         SCAN: begin
            cum_d = cum_nxt;
            idx_d = idx_q + 1'b1;
            if (cum_nxt > r_q) begin
               state_d     = IDLE;
               sel_valid_d = 1'b1;
               sel_idx_d   = idx_q;
            end else if (idx_q == IDX_W'(NUM_STATES - 1)) begin
               state_d     = IDLE;
               sel_valid_d = 1'b1;
               sel_idx_d   = last_nz;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         r_q         <= '0;
         cum_q       <= '0;
         idx_q       <= '0;
         sel_idx_q   <= '0;
         sel_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         cum_q       <= cum_d;
         idx_q       <= idx_d;
         sel_idx_q   <= sel_idx_d;
         sel_valid_q <= sel_valid_d;
         err_q       <= err_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign sel_valid = sel_valid_q;
   assign sel_idx   = sel_idx_q;
   assign err       = err_q;

endmodule

// File: doc/weighted_sampler.md
WEIGHTED_SAMPLER -- requirements
Module: weighted_sampler

Interface
REQ-001 SHALL have parameter NUM_STATES, default 4, meaning number of selectable states (legal range 2..16).
REQ-002 SHALL have parameter WEIGHT_W, default 8, meaning weight width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port w_wr_en, input, 1, weight write strobe.
REQ-006 SHALL have port w_wr_addr, input, IDX_W = clog2(NUM_STATES), weight index to write.
REQ-007 SHALL have port w_wr_data, input, WEIGHT_W, weight value.
REQ-008 SHALL have port start, input, 1, sample request.
REQ-009 SHALL have port rand_in, input, 12, random value in [0, sum] from the random stage.
REQ-010 SHALL have port sum, output, 12, registered total of all weights, fed to the random stage.
REQ-011 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-012 SHALL have port sel_valid, output, 1, one-cycle pulse marking a result.
REQ-013 SHALL have port sel_idx, output, IDX_W, selected state index, held until the next result.
REQ-014 SHALL have port err, output, 1, one-cycle pulse when sampling with sum == 0.

Function
REQ-015 SHALL use FSM states IDLE, CAPTURE, SCAN; IDLE->CAPTURE on start, CAPTURE->SCAN when sum != 0, else CAPTURE->IDLE; SCAN->IDLE on match or after index NUM_STATES-1.
REQ-016 SHALL apply a weight write only in IDLE, updating sum <= sum - w[addr] + w_wr_data on the same edge; writes in CAPTURE/SCAN SHALL be ignored.
REQ-017 SHALL, for a write and start sampled together at edge E, apply both and sample with the new weights.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL latch rand_in into r at edge E+1, where E is the edge that accepts start.
REQ-020 SHALL, at edge E+2+i, form cum_i = cum_(i-1) + w[i] in 12 bits, and select i on the first cum_i > r.
REQ-021 SHALL, when no index matches (r == sum), select the highest index with a nonzero weight, at edge E+1+NUM_STATES.
REQ-022 SHALL register sel_idx and assert sel_valid on the deciding edge: latency k+2 for a match at index k, NUM_STATES+1 for the fallback.
REQ-023 SHALL, when sum == 0 at edge E+1, pulse err and sel_valid with sel_idx = 0 and perform no scan.
REQ-024 SHALL return to IDLE on the sel_valid edge, so busy is low during the sel_valid cycle and a start there is accepted (back-to-back).
REQ-025 SHALL never overflow: NUM_STATES*(2^WEIGHT_W-1) <= 4095, enforced by elaboration check.

Reset
REQ-026 SHALL, on reset (including mid-scan), force state IDLE, and set busy, sel_valid, err, sel_idx, r and cum to 0.
REQ-027 SHALL reset all weights to 0 and sum to 0, unless REQ-028 applies.

Configuration
REQ-028 SHALL, with SAMPLER_UNIFORM_INIT_EN defined, reset every weight to 1 and sum to NUM_STATES; without it, weights and sum reset to 0.

Structure
REQ-029 SHALL take the FSM state enum, SUM_W = 12 and the index-width function from the shared package sampler_pkg.
REQ-030 SHALL place the weight register file and incremental sum in sub-module sampler_weight_table.

Verification
REQ-031 SHALL check weights {1,2,3,4}: sum = 10; rand_in = 0 gives sel_idx 0 at E+2; rand_in = 3 gives sel_idx 2 at E+4.
REQ-032 SHALL check weights {1,2,3,4} with rand_in = 10: fallback sel_idx 3 at E+5.
REQ-033 SHALL check weights {0,5,0,0} with rand_in = 5: sel_idx 1 at E+5.
REQ-034 SHALL check all-zero weights with start: err and sel_valid at E+1, sel_idx 0, busy low at E+2.
REQ-035 SHALL check reset asserted at E+3 during a scan: outputs 0 immediately, and no sel_valid follows.
REQ-036 SHALL check with SAMPLER_UNIFORM_INIT_EN: after reset sum = 4; a write to index 2 with value 7 during SCAN leaves sum = 4.
